// File: rtl/inst_queue_if.sv
// inst_queue_if: decoder push port, occupancy flags and CUR_INST issue port
// of the decoded-instruction queue, grouped into one bundle.
interface inst_queue_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned OP_W  = 5,
    parameter int unsigned REG_W = 5
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    // Decoder push side
    logic              in_push;
    logic [OP_W-1:0]   in_operator_type;
    logic [REG_W-1:0]  in_reg_1;
    logic [REG_W-1:0]  in_reg_2;
    logic [REG_W-1:0]  in_reg_3;

    // Occupancy
    logic              out_full;
    logic              out_empty;
    logic [CNT_W-1:0]  out_count;

    // Redirect and CUR_INST issue side
    logic              in_flush;
    logic              in_fetch_req;
    logic              out_fetch_next;
    logic [OP_W-1:0]   out_operator_type;
    logic [REG_W-1:0]  out_reg_1;
    logic [REG_W-1:0]  out_reg_2;
    logic [REG_W-1:0]  out_reg_3;

    // Decoder / CUR_INST / redirect view
    modport master (
        output in_push, in_operator_type, in_reg_1, in_reg_2, in_reg_3,
        output in_flush, in_fetch_req,
        input  out_full, out_empty, out_count,
        input  out_fetch_next, out_operator_type, out_reg_1, out_reg_2, out_reg_3
    );

    // Queue view
    modport slave (
        input  in_push, in_operator_type, in_reg_1, in_reg_2, in_reg_3,
        input  in_flush, in_fetch_req,
        output out_full, out_empty, out_count,
        output out_fetch_next, out_operator_type, out_reg_1, out_reg_2, out_reg_3
    );
endinterface

// File: rtl/inst_queue.sv
// inst_queue: decoded-instruction FIFO feeding the Tomasulo CUR_INST stage.
// Circular buffer with separate count; a three-state issue FSM hands out one
// entry per request level and strobes out_fetch_next for one cycle.
// Optional feature: define INST_QUEUE_BYPASS_EN to let a push into an empty,
// idle queue with a pending request go straight to the output registers.
module inst_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned OP_W  = 5,
    parameter int unsigned REG_W = 5
) (
    input  logic        clk,
    input  logic        in_reset,
    inst_queue_if.slave q_if
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = OP_W + 3 * REG_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [ENT_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_d;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               full_q;
    logic               empty_q;

    logic               fetch_next_q;
    logic               fetch_next_d;
    logic [ENT_W-1:0]   out_q;
    logic [ENT_W-1:0]   out_d;

    logic [ENT_W-1:0]   push_ent_c;
    logic               queue_empty_c;
    logic               queue_full_c;
    logic               pop_c;
    logic               bypass_c;
    logic               push_c;

    // Pushed entry packed as {operator, reg_1, reg_2, reg_3}
    assign push_ent_c    = {q_if.in_operator_type, q_if.in_reg_1, q_if.in_reg_2, q_if.in_reg_3};
    assign queue_empty_c = (count_q == '0);
    assign queue_full_c  = (count_q == CNT_W'(DEPTH));

    // FSM state register
    always_ff @(posedge clk) begin
        if (in_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: flush aborts any issue in progress
    always_comb begin
        state_d = state_q;
        if (q_if.in_flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop_c || bypass_c) begin
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (!q_if.in_fetch_req) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // FSM outputs: pop/bypass decision, next output fields and strobe
    always_comb begin
        pop_c        = 1'b0;
        bypass_c     = 1'b0;
        out_d        = out_q;
        fetch_next_d = 1'b0;
        if (!q_if.in_flush && (state_q == S_IDLE) && q_if.in_fetch_req) begin
            if (!queue_empty_c) begin
                pop_c = 1'b1;
                out_d = mem_q[rd_ptr_q];
            end
`ifdef INST_QUEUE_BYPASS_EN
            else if (q_if.in_push) begin
                bypass_c = 1'b1;
                out_d    = push_ent_c;
            end
`endif
        end
        if (!q_if.in_flush && (state_q == S_IDLE) && (pop_c || bypass_c)) begin
            fetch_next_d = 1'b1;
        end
    end

    // Push acceptance, pointer advance and occupancy update
    always_comb begin
        push_c   = q_if.in_push && !q_if.in_flush && !bypass_c && (!queue_full_c || pop_c);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (q_if.in_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_c && !push_c) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Pointer, count and registered flag state
    always_ff @(posedge clk) begin
        if (in_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CNT_W'(DEPTH));
            empty_q  <= (count_d == '0);
        end
    end

    // Entry storage; no reset needed since count gates every read
    always_ff @(posedge clk) begin
        if (!in_reset && push_c) begin
            mem_q[wr_ptr_q] <= push_ent_c;
        end
    end

    // Issued fields and strobe; fields only change on a pop or bypass
    always_ff @(posedge clk) begin
        if (in_reset) begin
            fetch_next_q <= 1'b0;
            out_q        <= '0;
        end else begin
            fetch_next_q <= fetch_next_d;
            out_q        <= out_d;
        end
    end

    assign q_if.out_full          = full_q;
    assign q_if.out_empty         = empty_q;
    assign q_if.out_count         = count_q;
    assign q_if.out_fetch_next    = fetch_next_q;
    assign q_if.out_operator_type = out_q[3*REG_W +: OP_W];
    assign q_if.out_reg_1         = out_q[2*REG_W +: REG_W];
    assign q_if.out_reg_2         = out_q[REG_W +: REG_W];
    assign q_if.out_reg_3         = out_q[0 +: REG_W];

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: vector table, directed corner sequences and a randomized run
// against a queue-based reference model of the instruction queue.
module tb_inst_queue;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned OP_W  = 5;
    localparam int unsigned REG_W = 5;
    localparam logic [4:0]  UMUL  = 5'h0A;
    localparam logic [4:0]  ADD   = 5'h00;

    logic clk;
    logic in_reset;

    inst_queue_if #(.DEPTH(DEPTH), .OP_W(OP_W), .REG_W(REG_W)) q_if ();

    inst_queue #(.DEPTH(DEPTH), .OP_W(OP_W), .REG_W(REG_W)) dut (
        .clk      (clk),
        .in_reset (in_reset),
        .q_if     (q_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    function automatic logic [19:0] fld(input logic [4:0] op, input logic [4:0] a,
                                        input logic [4:0] b, input logic [4:0] c);
        return {op, a, b, c};
    endfunction

    function automatic logic [19:0] dut_fld();
        return {q_if.out_operator_type, q_if.out_reg_1, q_if.out_reg_2, q_if.out_reg_3};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Apply one cycle of inputs, then sample just after the rising edge
    task automatic step(input logic push, input logic [4:0] op, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] c,
                        input logic req, input logic flush);
        q_if.in_push          = push;
        q_if.in_operator_type = op;
        q_if.in_reg_1         = a;
        q_if.in_reg_2         = b;
        q_if.in_reg_3         = c;
        q_if.in_fetch_req     = req;
        q_if.in_flush         = flush;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic req);
        step(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, req, 1'b0);
    endtask

    task automatic push1(input logic [4:0] op, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] c, input logic req);
        step(1'b1, op, a, b, c, req, 1'b0);
    endtask

    task automatic do_reset();
        in_reset = 1'b1;
        idle(1'b0);
        idle(1'b0);
        in_reset = 1'b0;
    endtask

    // Vector table: one row per cycle, expectations after that cycle's edge
    typedef struct {
        logic        push;
        logic [4:0]  op, r1, r2, r3;
        logic        req, flush;
        int          cnt;
        logic        strobe;
        logic [19:0] f;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic push, input logic [4:0] op, input logic [4:0] a,
                       input logic [4:0] b, input logic [4:0] c, input logic req,
                       input logic flush, input int cnt, input logic strobe,
                       input logic [19:0] f);
        vec_t v;
        v.push = push; v.op = op; v.r1 = a; v.r2 = b; v.r3 = c;
        v.req = req; v.flush = flush; v.cnt = cnt; v.strobe = strobe; v.f = f;
        vecs.push_back(v);
    endtask

    // Reference model: plain FIFO plus "strobe pending" and "awaiting release"
    logic [19:0] mq[$];
    logic [19:0] m_f;
    logic        m_strobe;
    logic        m_hold;

    task automatic model_edge(input logic rst, input logic push, input logic [19:0] e,
                              input logic req, input logic flush);
        logic popped;
        logic byp;
        popped = 1'b0;
        byp    = 1'b0;
        if (rst) begin
            mq.delete();
            m_f = '0; m_strobe = 1'b0; m_hold = 1'b0;
        end else if (flush) begin
            mq.delete();
            m_strobe = 1'b0; m_hold = 1'b0;
        end else begin
            if (m_strobe) begin
                m_strobe = 1'b0;
                m_hold   = 1'b1;
            end else if (m_hold) begin
                if (!req) m_hold = 1'b0;
            end else if (req && mq.size() > 0) begin
                m_f      = mq.pop_front();
                popped   = 1'b1;
                m_strobe = 1'b1;
            end
`ifdef INST_QUEUE_BYPASS_EN
            else if (req && push) begin
                m_f      = e;
                m_strobe = 1'b1;
                byp      = 1'b1;
            end
`endif
            if (push && !byp && (mq.size() < DEPTH || popped)) mq.push_back(e);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        q_if.in_push = 1'b0; q_if.in_operator_type = '0;
        q_if.in_reg_1 = '0; q_if.in_reg_2 = '0; q_if.in_reg_3 = '0;
        q_if.in_fetch_req = 1'b0; q_if.in_flush = 1'b0;
        in_reset = 1'b1;
        idle(1'b0);
        idle(1'b0);

        // Reset state
        chk("rst_count",  32'(q_if.out_count), 32'd0);
        chk("rst_empty",  32'(q_if.out_empty), 32'd1);
        chk("rst_full",   32'(q_if.out_full), 32'd0);
        chk("rst_strobe", 32'(q_if.out_fetch_next), 32'd0);
        chk("rst_fields", 32'(dut_fld()), 32'd0);
        in_reset = 1'b0;

        // Table: single push/issue, held request, flush with push
        add(1, UMUL, 0, 1, 2, 0, 0, 1, 0, fld(0, 0, 0, 0));
        add(0, 0, 0, 0, 0, 1, 0, 0, 1, fld(UMUL, 0, 1, 2));
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, fld(UMUL, 0, 1, 2));
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, fld(UMUL, 0, 1, 2));
        add(1, UMUL, 2, 4, 5, 0, 0, 1, 0, fld(UMUL, 0, 1, 2));
        add(1, ADD, 0, 3, 7, 0, 0, 2, 0, fld(UMUL, 0, 1, 2));
        add(0, 0, 0, 0, 0, 1, 0, 1, 1, fld(UMUL, 2, 4, 5));
        for (int i = 0; i < 9; i++) add(0, 0, 0, 0, 0, 1, 0, 1, 0, fld(UMUL, 2, 4, 5));
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, fld(UMUL, 2, 4, 5));
        add(0, 0, 0, 0, 0, 1, 0, 0, 1, fld(ADD, 0, 3, 7));
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, fld(ADD, 0, 3, 7));
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, fld(ADD, 0, 3, 7));
        for (int i = 0; i < 5; i++)
            add(1, 5'(i + 1), 5'(i), 5'(i), 5'(i), 0, 0, i + 1, 0, fld(ADD, 0, 3, 7));
        add(1, 5'd9, 5'd9, 5'd9, 5'd9, 0, 1, 0, 0, fld(ADD, 0, 3, 7));
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, fld(ADD, 0, 3, 7));
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, fld(ADD, 0, 3, 7));
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, fld(ADD, 0, 3, 7));

        foreach (vecs[i]) begin
            step(vecs[i].push, vecs[i].op, vecs[i].r1, vecs[i].r2, vecs[i].r3,
                 vecs[i].req, vecs[i].flush);
            chk($sformatf("vec%0d_count", i), 32'(q_if.out_count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d_empty", i), 32'(q_if.out_empty), 32'(vecs[i].cnt == 0));
            chk($sformatf("vec%0d_strobe", i), 32'(q_if.out_fetch_next), 32'(vecs[i].strobe));
            chk($sformatf("vec%0d_fields", i), 32'(dut_fld()), 32'(vecs[i].f));
        end

        // Fill past capacity, then drain in order
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) push1(5'(i), 5'(i), 5'(i + 1), 5'(i + 2), 1'b0);
        chk("full_count", 32'(q_if.out_count), 32'(DEPTH));
        chk("full_flag",  32'(q_if.out_full), 32'd1);
        for (int k = 0; k < DEPTH; k++) begin
            idle(1'b1);
            chk($sformatf("drain%0d_strobe", k), 32'(q_if.out_fetch_next), 32'd1);
            chk($sformatf("drain%0d_fields", k), 32'(dut_fld()),
                32'(fld(5'(k), 5'(k), 5'(k + 1), 5'(k + 2))));
            chk($sformatf("drain%0d_count", k), 32'(q_if.out_count), 32'(DEPTH - 1 - k));
            idle(1'b0);
            idle(1'b0);
        end
        chk("drain_empty", 32'(q_if.out_empty), 32'd1);
        idle(1'b1);
        chk("drain_nostrobe", 32'(q_if.out_fetch_next), 32'd0);
        idle(1'b0);

        // Same-cycle push and pop while full
        do_reset();
        for (int i = 0; i < DEPTH; i++) push1(5'(20 + i), 5'(i), 5'(i), 5'(i), 1'b0);
        push1(5'd28, 5'd1, 5'd1, 5'd1, 1'b1);
        chk("fullpp_count",  32'(q_if.out_count), 32'(DEPTH));
        chk("fullpp_full",   32'(q_if.out_full), 32'd1);
        chk("fullpp_strobe", 32'(q_if.out_fetch_next), 32'd1);
        chk("fullpp_fields", 32'(dut_fld()), 32'(fld(5'd20, 5'd0, 5'd0, 5'd0)));
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);
        chk("fullpp_next", 32'(q_if.out_operator_type), 32'd21);
        idle(1'b0);
        idle(1'b0);

        // Pointer wrap with push and pop in the same cycle, count held at 2
        do_reset();
        push1(5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        push1(5'd1, 5'd1, 5'd1, 5'd1, 1'b0);
        for (int i = 2; i < 20; i++) begin
            push1(5'(i), 5'(i), 5'(i), 5'(i), 1'b1);
            chk($sformatf("wrap%0d_strobe", i), 32'(q_if.out_fetch_next), 32'd1);
            chk($sformatf("wrap%0d_fields", i), 32'(dut_fld()),
                32'(fld(5'(i - 2), 5'(i - 2), 5'(i - 2), 5'(i - 2))));
            chk($sformatf("wrap%0d_count", i), 32'(q_if.out_count), 32'd2);
            idle(1'b0);
            idle(1'b0);
        end

        // Push together with a request into an empty idle queue
        do_reset();
        idle(1'b0);
        push1(ADD, 5'd1, 5'd2, 5'd3, 1'b1);
`ifdef INST_QUEUE_BYPASS_EN
        chk("byp_strobe", 32'(q_if.out_fetch_next), 32'd1);
        chk("byp_count",  32'(q_if.out_count), 32'd0);
        chk("byp_fields", 32'(dut_fld()), 32'(fld(ADD, 5'd1, 5'd2, 5'd3)));
        idle(1'b1);
        chk("byp_after",  32'(q_if.out_fetch_next), 32'd0);
`else
        chk("nobyp_strobe0", 32'(q_if.out_fetch_next), 32'd0);
        chk("nobyp_count1",  32'(q_if.out_count), 32'd1);
        idle(1'b1);
        chk("nobyp_strobe1", 32'(q_if.out_fetch_next), 32'd1);
        chk("nobyp_count0",  32'(q_if.out_count), 32'd0);
        chk("nobyp_fields",  32'(dut_fld()), 32'(fld(ADD, 5'd1, 5'd2, 5'd3)));
`endif
        idle(1'b0);
        idle(1'b0);

        // Randomized run against the reference model
        do_reset();
        model_edge(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int n = 0; n < 4000; n++) begin
            logic        r_rst, r_push, r_req, r_flush;
            logic [19:0] e;
            r_rst   = ($urandom_range(0, 199) == 0);
            r_flush = ($urandom_range(0, 63) == 0);
            r_push  = ($urandom_range(0, 99) < 55);
            r_req   = ($urandom_range(0, 99) < 50);
            e       = 20'($urandom);
            model_edge(r_rst, r_push, e, r_req, r_flush);
            in_reset = r_rst;
            step(r_push, e[19:15], e[14:10], e[9:5], e[4:0], r_req, r_flush);
            in_reset = 1'b0;
            chk("rnd_strobe", 32'(q_if.out_fetch_next), 32'(m_strobe));
            chk("rnd_count",  32'(q_if.out_count), 32'(mq.size()));
            chk("rnd_empty",  32'(q_if.out_empty), 32'(mq.size() == 0));
            chk("rnd_full",   32'(q_if.out_full), 32'(mq.size() == DEPTH));
            chk("rnd_fields", 32'(dut_fld()), 32'(m_f));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
